// File: rtl/matvec_mac_seq.sv
// Purpose: matrix-vector sequencer; dot-products one FIFO-resident int8 vector against NumRows streamed weight rows.
// Latency: row result valid one cycle after its last weight beat; B+1 cycles per row with res_ready held high.
// Backpressure: weight beats wait on wt_valid; a pending result holds (stable) until res_ready, stalling the next row.
//
// Ports:
//   clk_in, rst_in_n        clock, asynchronous active-low reset
//   start, vec_ready        job start pulse (honoured only in IDLE); vector-present flag (sampled in WAIT_VEC)
//   fifo_rd_en/_wrap_rd     FIFO read-pointer advance / rewind-to-zero strobes
//   fifo_rd_data            FIFO read data, combinational from the FIFO
//   wt_valid/_ready/_data   int8 weight stream, byte i pairs with fifo_rd_data[i]
//   res_valid/_ready/_data  signed dot-product result handshake
//   busy, done              not-IDLE flag; one-cycle pulse after the final result is accepted
// Build option: define MATVEC_RELU_EN to clamp negative results to zero at the output.
module matvec_mac_seq #(
    parameter int VecElements  = 16,
    parameter int BytesPerRead = 4,
    parameter int NumRows      = 8,
    parameter int AccWidth     = 24
) (
    input  logic                         clk_in,
    input  logic                         rst_in_n,
    input  logic                         start,
    input  logic                         vec_ready,
    output logic                         fifo_rd_en,
    output logic                         fifo_wrap_rd,
    input  logic [BytesPerRead-1:0][7:0] fifo_rd_data,
    input  logic                         wt_valid,
    output logic                         wt_ready,
    input  logic [BytesPerRead-1:0][7:0] wt_data,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic signed [AccWidth-1:0]   res_data,
    output logic                         busy,
    output logic                         done
);

    localparam int Beats = VecElements / BytesPerRead;
    localparam int BeatW = (Beats > 1) ? $clog2(Beats) : 1;
    localparam int RowW  = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);
    localparam logic [RowW-1:0]  LastRow  = RowW'(NumRows - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_VEC,
        S_MAC,
        S_EMIT
    } state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [BeatW-1:0]           r_beat_cnt;
    logic [RowW-1:0]            r_row_cnt;
    logic signed [AccWidth-1:0] r_acc;
    logic                       r_done;

    logic                       w_fire;
    logic                       w_accept;
    logic                       w_last_beat;
    logic                       w_last_row;
    logic signed [15:0]         w_prod [BytesPerRead];
    logic signed [AccWidth-1:0] w_sum;

    assign w_last_beat = (r_beat_cnt == LastBeat);
    assign w_last_row  = (r_row_cnt == LastRow);

    // One beat's partial dot product: 16-bit signed products, sign-extended before summing.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < BytesPerRead; i++) begin
            w_prod[i] = 16'($signed(fifo_rd_data[i])) * 16'($signed(wt_data[i]));
            w_sum     = w_sum + {{(AccWidth-16){w_prod[i][15]}}, w_prod[i]};
        end
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The last beat rewinds instead of advancing, so the pointer sits at 0 for the
    // next row (and the next job) without a separate rewind cycle.
    always_comb begin
        w_next       = r_state;
        wt_ready     = 1'b0;
        fifo_rd_en   = 1'b0;
        fifo_wrap_rd = 1'b0;
        res_valid    = 1'b0;
        busy         = 1'b1;
        w_fire       = 1'b0;
        w_accept     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = S_WAIT_VEC;
            end
            S_WAIT_VEC: begin
                if (vec_ready) w_next = S_MAC;
            end
            S_MAC: begin
                wt_ready = 1'b1;
                if (wt_valid) begin
                    w_fire = 1'b1;
                    if (w_last_beat) begin
                        fifo_wrap_rd = 1'b1;
                        w_next       = S_EMIT;
                    end else begin
                        fifo_rd_en = 1'b1;
                    end
                end
            end
            S_EMIT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_accept = 1'b1;
                    w_next   = w_last_row ? S_IDLE : S_MAC;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_acc      <= '0;
            r_beat_cnt <= '0;
            r_row_cnt  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_accept && w_last_row;
            if (w_fire) begin
                // Beat 0 overwrites the accumulator, so no clear cycle between rows.
                r_acc      <= (r_beat_cnt == '0) ? w_sum : r_acc + w_sum;
                r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + BeatW'(1);
            end
            if (w_accept) begin
                r_row_cnt <= w_last_row ? '0 : r_row_cnt + RowW'(1);
            end
        end
    end

`ifdef MATVEC_RELU_EN
    assign res_data = r_acc[AccWidth-1] ? '0 : r_acc;
`else
    assign res_data = r_acc;
`endif

    assign done = r_done;

endmodule

// File: doc/matvec_mac_seq.md
# matvec_mac_seq

Matrix-vector multiply sequencer sitting directly downstream of the vector FIFO. It repeatedly reads one stored int8 input vector out of the FIFO, one row of weights at a time. For each row it:
- multiplies the vector bytes against a streamed int8 weight row,
- accumulates the dot product and emits one signed result,
- rewinds the FIFO read pointer with `wrap_rd` so the same vector is reused for the next row.

## Interface
Parameters:
- `VecElements`, 16, int8 elements per input vector; must be a multiple of `BytesPerRead`
- `BytesPerRead`, 4, bytes consumed from FIFO and weight stream per beat; must match the FIFO's `BytesPerRead`
- `NumRows`, 8, weight rows (results) per `start`
- `AccWidth`, 24, signed accumulator/result width; must be ≥ 16 + clog2(VecElements)

Ports:
- `clk_in`  in  1  clock; all logic on rising edge
- `rst_in_n`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle pulse; begins a `NumRows` job when idle
- `vec_ready`  in  1  upstream has written a full vector into the FIFO
- `fifo_rd_en`  out  1  to FIFO `rd_en`; advance read pointer one beat
- `fifo_wrap_rd`  out  1  to FIFO `wrap_rd`; rewind read pointer to 0
- `fifo_rd_data`  in  [BytesPerRead-1:0][7:0]  from FIFO `rd_data`; combinational, valid same cycle
- `wt_valid`  in  1  weight beat valid
- `wt_ready`  out  1  weight beat accepted when `wt_valid & wt_ready`
- `wt_data`  in  [BytesPerRead-1:0][7:0]  signed int8 weights, byte i pairs with `fifo_rd_data[i]`
- `res_valid`  out  1  result valid; held until accepted
- `res_ready`  in  1  downstream accepts result
- `res_data`  out  AccWidth  signed dot product
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse after the last result is accepted

## Operation
- Beats per row B = VecElements/BytesPerRead. Counters: `beat_cnt` (0..B-1), `row_cnt` (0..NumRows-1).
- FSM states and transitions:
  - IDLE: `start` → WAIT_VEC.
  - WAIT_VEC: `vec_ready` → MAC.
  - MAC: `wt_ready`=1. A beat fires when `wt_valid`=1.
    - Non-last beat: assert `fifo_rd_en`.
    - Last beat (`beat_cnt`=B-1): assert `fifo_wrap_rd` and hold `fifo_rd_en`=0, then → EMIT.
    - No fire: both FIFO strobes 0, nothing changes.
  - EMIT: `res_valid`=1.
    - On `res_ready`, if `row_cnt`<NumRows-1: `row_cnt`++, → MAC.
    - Otherwise pulse `done`, clear counters, → IDLE.
- Per fired beat: sum = Σ sext(`fifo_rd_data[i]`)·sext(`wt_data[i]`), each product 16-bit signed, sum sign-extended to AccWidth.
  - `beat_cnt`=0: acc ← sum (no clear cycle).
  - Otherwise: acc ← acc+sum, modulo 2^AccWidth.
- `start` outside IDLE is ignored. `vec_ready` is sampled only in WAIT_VEC. It is not rechecked between rows, because the vector is retained in the FIFO.
- The FIFO read pointer is left at 0 after every row, and therefore at 0 for the next job.

## Timing
- Reset (`rst_in_n`=0) forces, immediately and asynchronously:
  - state to IDLE;
  - `acc`, `beat_cnt`, `row_cnt` to 0;
  - all outputs to 0: `fifo_rd_en`, `fifo_wrap_rd`, `wt_ready`, `res_valid`, `res_data`, `busy`, `done`.
- Reset mid-job abandons the job; no result is emitted. The FIFO pointer is not rewound by this block; the FIFO must be reset alongside.
- All FIFO strobes and `wt_ready` are combinational from registered state and `wt_valid`.
- `start` edge → `busy`=1 next cycle.
- Zero stalls: `vec_ready` sample → first beat next cycle.
  - Row latency: B beat cycles, then `res_valid` on the following cycle.
  - Row throughput: B+1 cycles when `res_ready` is tied high.
- `res_data` is stable while `res_valid`=1 and `res_ready`=0. No FIFO strobe or `wt_ready` is asserted during EMIT.
- `done` is asserted in the cycle after the final `res_valid & res_ready`.

## Configuration
- `MATVEC_RELU_EN` defined: `res_data` = acc<0 ? 0 : acc (ReLU applied at output only; acc itself is unclamped).
- Not defined: `res_data` = acc, raw signed.

## Test plan
- Default params, NumRows=2, vector all 1, row0 weights all 2, row1 all −1, `res_ready`=1 → results 32 then −16 (0 with `MATVEC_RELU_EN`). Per row: 3 `fifo_rd_en` pulses then 1 `fifo_wrap_rd`. `done` pulses once.
- Same stimulus with `wt_valid` toggling every cycle → identical results; FIFO strobes only on cycles with `wt_valid`=1; row takes 8 cycles of MAC.
- `res_ready` held low 5 cycles in EMIT → `res_valid` and `res_data` stable; `wt_ready`=0; no FIFO strobes; proceeds on the cycle `res_ready` rises.
- Vector all −128, weights all −128 → result 262144. Vector all 127, weights all −128 → −260096 (0 with ReLU).
- `rst_in_n` low during beat 2 of row 0 → all outputs 0 with no clock edge. After release, plus FIFO reset and refill, a new `start` gives correct results.
- `start` pulsed during MAC and during EMIT → ignored; exactly NumRows results and one `done`.
